accum_stage_driver: RTL and testbench
=====================================

Name: accum_stage_driver

Overview:
Transmit-side counterpart of the accumulator stage. It buffers operands from an upstream valid/ready source in a small FIFO and issues exactly burst_len words toward the accumulator as a stg_en/stg_data stream. A start/done control handshake frames each burst. It sits directly upstream of the accumulator in the accumulate pipeline.

Parameters:
DATA_WIDTH, 32, width of operand words and of stg_data.
ACCUM_INIT, 0, idle value driven on stg_data whenever stg_en=0; matches the accumulator init value.
FIFO_DEPTH, 8, operand FIFO entries; must be a power of 2 and at least 2.
LEN_W, 8, width of burst_len and of the issue counter.

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
in_valid  in  1  upstream word valid
in_ready  out  1  FIFO can accept a word (= !full)
in_data  in  DATA_WIDTH  upstream word
start  in  1  begin a burst; sampled only in IDLE
burst_len  in  LEN_W  number of words to issue; latched on start
abort  in  1  terminate the current burst
busy  out  1  high in FEED
done  out  1  one-cycle pulse when a burst completes normally
stg_en  out  1  stage enable to the accumulator
stg_data  out  DATA_WIDTH  stage data to the accumulator

Behaviour:
- Reset (rst_n=0 at posedge):
  - FIFO emptied; state=IDLE; issue counter=0.
  - busy=0, done=0, stg_en=0, stg_data=ACCUM_INIT; in_ready=1 in the cycle after reset.
  - Reset mid-burst discards the burst and all buffered words. done is not pulsed.
- FIFO:
  - Push when in_valid && in_ready.
  - Pop only in FEED when the FIFO is non-empty.
  - Push and pop in the same cycle are both performed; occupancy is unchanged.
  - When full, in_ready=0, so no push occurs even if a pop happens that cycle. in_ready rises the cycle after the pop.
  - Pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished with an extra pointer bit.
- Latency:
  - No bypass path. A word accepted at edge N can appear on stg_data with stg_en=1 no earlier than after edge N+1.
  - With an empty FIFO in FEED, a word accepted at edge N is issued (stg_en=1) in the cycle after edge N+1.
- States:
  - IDLE:
    - stg_en=0, stg_data=ACCUM_INIT.
    - start=1 with burst_len!=0 → FEED. Latch burst_len; counter=0.
    - start=1 with burst_len=0 → DONE with no words issued.
  - FEED:
    - busy=1.
    - Each cycle the FIFO is non-empty: pop, register stg_en=1 and stg_data=word, counter+1.
    - FIFO empty: register stg_en=0, stg_data=ACCUM_INIT. This is a gap; the state is held.
    - After the pop that makes counter==burst_len → DONE.
    - abort=1 → IDLE next cycle. No pop occurs that cycle, done stays 0, and remaining FIFO words are retained.
    - abort has priority over a pop in the same cycle.
  - DONE:
    - done=1 for exactly one cycle; stg_en=0.
    - Next state is IDLE.
    - start asserted in DONE is ignored.
- Outputs stg_en, stg_data and done are registered. busy decodes directly from state.
- Words left in the FIFO after a burst remain for the next burst.
- start in FEED or DONE is ignored. abort in IDLE or DONE is ignored.

Optional Feature:
Macro ACCUM_DRV_GAP_CNT_EN.
- With the macro defined:
  - Adds output port gap_cnt [15:0]: a count of FEED cycles in which the FIFO was empty (stall cycles).
  - Cleared by reset and on each accepted start.
  - Saturates at 16'hFFFF and holds its value in IDLE.
- Without the macro: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
- Preload 4 words (0x11, 0x22, 0x33, 0x44) in IDLE, then start with burst_len=4 → stg_en high 4 consecutive cycles with 0x11..0x44 in order; done pulses 1 cycle after the last word; busy=0 afterwards.
- Hold in_valid=1 with no burst active → in_ready=0 after 8 accepts; the 9th word is not accepted; start with burst_len=1 → in_ready=1 one cycle after the pop.
- Start burst_len=3 with an empty FIFO, then push 0xA0 at edge N → stg_en=1, stg_data=0xA0 after edge N+1; stg_data=ACCUM_INIT during gap cycles; gap_cnt equals the empty cycles (macro on).
- start with burst_len=0 → no stg_en; done pulses once, 2 cycles after start.
- Preload 6 words, burst_len=6, assert abort after 2 issued → third word not issued; done=0; IDLE; a new burst_len=4 issues words 3..6.
- Assert rst_n=0 mid-burst with 3 words buffered → stg_en=0, stg_data=ACCUM_INIT, FIFO empty, in_ready=1 after reset release; no done pulse.

Source files
------------

// File: rtl/accum_stage_driver.sv
// Operand FIFO plus burst sequencer that feeds the accumulator stage (stg_en/stg_data).
// Optional stall counter output gap_cnt is enabled with `define ACCUM_DRV_GAP_CNT_EN.
module accum_stage_driver #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] ACCUM_INIT = '0,
    parameter int unsigned           FIFO_DEPTH = 8,
    parameter int unsigned           LEN_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  start,
    input  logic [LEN_W-1:0]      burst_len,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  stg_en,
    output logic [DATA_WIDTH-1:0] stg_data
`ifdef ACCUM_DRV_GAP_CNT_EN
    ,
    output logic [15:0]           gap_cnt
`endif
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FEED = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [LEN_W-1:0]      cnt_q, cnt_d;
    logic [LEN_W-1:0]      cnt_inc;
    logic                  stg_en_q, stg_en_d;
    logic [DATA_WIDTH-1:0] stg_data_q, stg_data_d;
    logic                  done_q, done_d;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic                  fifo_empty, fifo_full;
    logic                  push, pop;
    logic [DATA_WIDTH-1:0] rd_word;

    // Extra pointer MSB separates full from empty when the index bits match.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push       = in_valid && !fifo_full;
    assign rd_word    = mem_q[rd_ptr_q[AW-1:0]];
    assign cnt_inc    = cnt_q + LEN_W'(1);

    assign in_ready = !fifo_full;
    assign busy     = (state_q == ST_FEED);
    assign done     = done_q;
    assign stg_en   = stg_en_q;
    assign stg_data = stg_data_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            stg_en_q   <= 1'b0;
            stg_data_q <= ACCUM_INIT;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            stg_en_q   <= stg_en_d;
            stg_data_q <= stg_data_d;
            done_q     <= done_d;
        end
    end

    // Abort wins over a pop; an empty FIFO in FEED issues an idle gap word.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        stg_en_d   = 1'b0;
        stg_data_d = ACCUM_INIT;
        done_d     = 1'b0;
        pop        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d   = burst_len;
                    cnt_d   = '0;
                    state_d = (burst_len != '0) ? ST_FEED : ST_DONE;
                end
            end
            ST_FEED: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (!fifo_empty) begin
                    pop        = 1'b1;
                    stg_en_d   = 1'b1;
                    stg_data_d = rd_word;
                    cnt_d      = cnt_inc;
                    if (cnt_inc == len_q) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef ACCUM_DRV_GAP_CNT_EN
    logic [15:0] gap_cnt_q, gap_cnt_d;

    // Stall cycles of the current burst, saturating; frozen outside FEED.
    always_comb begin
        gap_cnt_d = gap_cnt_q;
        if (state_q == ST_IDLE && start) begin
            gap_cnt_d = '0;
        end else if (state_q == ST_FEED && fifo_empty && gap_cnt_q != 16'hFFFF) begin
            gap_cnt_d = gap_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) gap_cnt_q <= '0;
        else        gap_cnt_q <= gap_cnt_d;
    end

    assign gap_cnt = gap_cnt_q;
`endif

endmodule

// File: tb/tb_accum_stage_driver.sv
// Self-checking bench for accum_stage_driver: scoreboard of pushed words versus issued stg_data.
// Stall counter checks are included when ACCUM_DRV_GAP_CNT_EN is defined.
module tb_accum_stage_driver;

    localparam int unsigned DW = 32;
    localparam logic [DW-1:0] INIT = 32'h0;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          start;
    logic [7:0]    burst_len;
    logic          abort;
    logic          busy;
    logic          done;
    logic          stg_en;
    logic [DW-1:0] stg_data;
`ifdef ACCUM_DRV_GAP_CNT_EN
    logic [15:0]   gap_cnt;
`endif

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_w;

    accum_stage_driver #(
        .DATA_WIDTH(DW),
        .ACCUM_INIT(INIT),
        .FIFO_DEPTH(8),
        .LEN_W(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .start(start),
        .burst_len(burst_len),
        .abort(abort),
        .busy(busy),
        .done(done),
        .stg_en(stg_en),
        .stg_data(stg_data)
`ifdef ACCUM_DRV_GAP_CNT_EN
        ,
        .gap_cnt(gap_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        exp_q.push_back(d);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_start(input logic [7:0] len);
        start     = 1'b1;
        burst_len = len;
        tick();
        start     = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (stg_en !== 1'b0) begin errors++; $display("FAIL reset_stg_en: got %b want 0", stg_en); end
        checks++; if (stg_data !== INIT) begin errors++; $display("FAIL reset_stg_data: got %h want %h", stg_data, INIT); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        push_word(32'h11);
        push_word(32'h22);
        push_word(32'h33);
        push_word(32'h44);
        do_start(8'd4);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            checks++; if (stg_en !== 1'b1) begin errors++; $display("FAIL basic_en%0d: got %b want 1", i, stg_en); end
            checks++; if (stg_data !== exp_w) begin errors++; $display("FAIL basic_data%0d: got %h want %h", i, stg_data, exp_w); end
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_early_done%0d: got %b want 0", i, done); end
        end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done: got %b want 1", done); end
        checks++; if (stg_en !== 1'b0) begin errors++; $display("FAIL basic_en_after: got %b want 0", stg_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b want 0", busy); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_full();
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = DW'(i + 1);
            exp_q.push_back(DW'(i + 1));
            tick();
        end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready_8: got %b want 0", in_ready); end
        in_data = 32'h9;
        tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready_9: got %b want 0", in_ready); end
        in_valid = 1'b0;
        do_start(8'd1);
        tick();
        exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        checks++; if (stg_en !== 1'b1) begin errors++; $display("FAIL full_pop_en: got %b want 1", stg_en); end
        checks++; if (stg_data !== exp_w) begin errors++; $display("FAIL full_pop_data: got %h want %h", stg_data, exp_w); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after_pop: got %b want 1", in_ready); end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL full_done1: got %b want 1", done); end
        // Drain the remaining seven; the rejected ninth word must not show up later.
        do_start(8'd7);
        for (int i = 0; i < 7; i++) begin
            tick();
            exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            checks++; if (stg_en !== 1'b1) begin errors++; $display("FAIL drain_en%0d: got %b want 1", i, stg_en); end
            checks++; if (stg_data !== exp_w) begin errors++; $display("FAIL drain_data%0d: got %h want %h", i, stg_data, exp_w); end
        end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL drain_done: got %b want 1", done); end
        tick();
    endtask

    task automatic test_gap();
        do_start(8'd3);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (stg_en !== 1'b0) begin errors++; $display("FAIL gap_en%0d: got %b want 0", i, stg_en); end
            checks++; if (stg_data !== INIT) begin errors++; $display("FAIL gap_data%0d: got %h want %h", i, stg_data, INIT); end
        end
        push_word(32'hA0);
        checks++; if (stg_en !== 1'b0) begin errors++; $display("FAIL gap_no_bypass: got %b want 0", stg_en); end
        tick();
        exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        checks++; if (stg_en !== 1'b1) begin errors++; $display("FAIL gap_a0_en: got %b want 1", stg_en); end
        checks++; if (stg_data !== exp_w) begin errors++; $display("FAIL gap_a0_data: got %h want %h", stg_data, exp_w); end
`ifdef ACCUM_DRV_GAP_CNT_EN
        checks++; if (gap_cnt !== 16'd3) begin errors++; $display("FAIL gap_cnt3: got %0d want 3", gap_cnt); end
`endif
        push_word(32'hB0);
        checks++; if (stg_en !== 1'b0) begin errors++; $display("FAIL gap_b0_gap: got %b want 0", stg_en); end
        push_word(32'hC0);
        exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        checks++; if (stg_data !== exp_w || stg_en !== 1'b1) begin errors++; $display("FAIL gap_b0_data: got %b/%h want 1/%h", stg_en, stg_data, exp_w); end
        tick();
        exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        checks++; if (stg_data !== exp_w || stg_en !== 1'b1) begin errors++; $display("FAIL gap_c0_data: got %b/%h want 1/%h", stg_en, stg_data, exp_w); end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL gap_done: got %b want 1", done); end
        tick();
        tick();
`ifdef ACCUM_DRV_GAP_CNT_EN
        checks++; if (gap_cnt !== 16'd4) begin errors++; $display("FAIL gap_cnt_hold: got %0d want 4", gap_cnt); end
`endif
    endtask

    task automatic test_zero_len();
        do_start(8'd0);
        checks++; if (done !== 1'b0 || stg_en !== 1'b0) begin errors++; $display("FAIL zero_first: got done=%b en=%b want 0/0", done, stg_en); end
        tick();
        checks++; if (done !== 1'b1 || stg_en !== 1'b0) begin errors++; $display("FAIL zero_done: got done=%b en=%b want 1/0", done, stg_en); end
        tick();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL zero_after: got done=%b busy=%b want 0/0", done, busy); end
    endtask

    task automatic test_abort();
        for (int i = 0; i < 6; i++) push_word(DW'(32'h61 + i));
        do_start(8'd6);
        for (int i = 0; i < 2; i++) begin
            tick();
            exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            checks++; if (stg_data !== exp_w || stg_en !== 1'b1) begin errors++; $display("FAIL abort_pre%0d: got %b/%h want 1/%h", i, stg_en, stg_data, exp_w); end
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if (stg_en !== 1'b0) begin errors++; $display("FAIL abort_no_issue: got %b want 0", stg_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle: got %b want 0", busy); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b want 0", done); end
        do_start(8'd4);
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            checks++; if (stg_data !== exp_w || stg_en !== 1'b1) begin errors++; $display("FAIL abort_resume%0d: got %b/%h want 1/%h", i, stg_en, stg_data, exp_w); end
        end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL abort_resume_done: got %b want 1", done); end
        tick();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) push_word(DW'(32'h71 + i));
        do_start(8'd5);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        checks++; if (stg_en !== 1'b0) begin errors++; $display("FAIL rstmid_en: got %b want 0", stg_en); end
        checks++; if (stg_data !== INIT) begin errors++; $display("FAIL rstmid_data: got %h want %h", stg_data, INIT); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
`ifdef ACCUM_DRV_GAP_CNT_EN
        checks++; if (gap_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_gap_cnt: got %0d want 0", gap_cnt); end
`endif
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b want 0", done); end
        // A fresh one-word burst must stall: the FIFO was emptied by reset.
        do_start(8'd1);
        tick();
        checks++; if (stg_en !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL rstmid_empty: got en=%b busy=%b want 0/1", stg_en, busy); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_abort: got %b want 0", busy); end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        start     = 1'b0;
        burst_len = '0;
        abort     = 1'b0;
        test_reset();
        test_basic();
        test_full();
        test_gap();
        test_zero_len();
        test_abort();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
